// File: rtl/store_write_buffer_pkg.sv
// Shared constants and entry type for the write-through store buffer.
package store_write_buffer_pkg;

  localparam int WB_DEPTH    = 4;
  localparam int WB_ADDR_W   = 16;
  localparam int WB_DATA_W   = 16;
  localparam int WB_LINE_OFF = 4;
  localparam int WORD_LSB    = 1;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_addr_match.sv
// CAM compare over the buffer entries: word hit with youngest-match data, plus line-match OR.
module wb_addr_match
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH    = WB_DEPTH,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int DATA_W   = WB_DATA_W,
  parameter int LINE_OFF = WB_LINE_OFF,
  parameter int PTR_W    = $clog2(WB_DEPTH)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data,
  output logic              line_hit
);

  logic [PTR_W-1:0] idx_s;
  logic             word_eq_s;
  logic             unused_lsb_s;

  assign unused_lsb_s = ^cmp_addr[WORD_LSB-1:0];

  // Walk oldest to youngest from head so the last match wins.
  always_comb begin
    hit       = 1'b0;
    data      = {DATA_W{1'b0}};
    line_hit  = 1'b0;
    idx_s     = {PTR_W{1'b0}};
    word_eq_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s     = head + PTR_W'(i);
      word_eq_s = entries[idx_s].valid &&
                  (entries[idx_s].addr[ADDR_W-1:WORD_LSB] == cmp_addr[ADDR_W-1:WORD_LSB]);
      hit       = hit | word_eq_s;
      data      = word_eq_s ? entries[idx_s].data : data;
      line_hit  = line_hit | (entries[i].valid &&
                  (entries[i].addr[ADDR_W-1:LINE_OFF] == cmp_addr[ADDR_W-1:LINE_OFF]));
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Write-through store buffer: FIFO of stores with coalescing, load forwarding
// and a line-conflict flag for the miss fill path.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH    = WB_DEPTH,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int DATA_W   = WB_DATA_W,
  parameter int LINE_OFF = WB_LINE_OFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  output logic                   st_ready,
  input  logic [ADDR_W-1:0]      ld_addr,
  output logic                   ld_hit,
  output logic [DATA_W-1:0]      ld_data,
  input  logic [ADDR_W-1:0]      miss_addr,
  output logic                   line_conflict,
  input  logic                   mem_gnt,
  output logic                   mem_wr_en,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wb_entry_t        entries_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] young_s;
  logic             accept_s;
  logic             coalesce_s;
  logic             push_s;
  logic             pop_s;
  logic             ld_line_s;
  logic             miss_hit_s;
  logic [DATA_W-1:0] miss_data_s;
  logic             unused_s;

  assign count     = count_r;
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == FULL_CNT);
  assign st_ready  = ~full;
  // Reset wins over a pending grant so nothing is written in the reset cycle.
  assign mem_wr_en = ~empty & mem_gnt & ~rst;
  assign mem_addr  = empty ? {ADDR_W{1'b0}} : entries_r[head_r].addr;
  assign mem_wdata = empty ? {DATA_W{1'b0}} : entries_r[head_r].data;

  assign young_s  = tail_r - PTR_W'(1);
  assign accept_s = st_valid & ~full;
  // Merge into the youngest entry unless that entry is leaving this cycle.
  assign coalesce_s = accept_s & ~empty & entries_r[young_s].valid &
                      (entries_r[young_s].addr[ADDR_W-1:WORD_LSB] == st_addr[ADDR_W-1:WORD_LSB]) &
                      ~(mem_wr_en & (young_s == head_r));
  assign push_s = accept_s & ~coalesce_s;
  assign pop_s  = mem_wr_en;

  assign unused_s = ^{ld_line_s, miss_hit_s, miss_data_s, st_addr[WORD_LSB-1:0]};

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i].valid <= 1'b0;
        entries_r[i].addr  <= {ADDR_W{1'b0}};
        entries_r[i].data  <= {DATA_W{1'b0}};
      end
    end else begin
      if (pop_s) begin
        entries_r[head_r].valid <= 1'b0;
        head_r                  <= head_r + PTR_W'(1);
      end
      if (push_s) begin
        entries_r[tail_r].valid <= 1'b1;
        entries_r[tail_r].addr  <= {st_addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
        entries_r[tail_r].data  <= st_data;
        tail_r                  <= tail_r + PTR_W'(1);
      end
      if (coalesce_s) begin
        entries_r[young_s].data <= st_data;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  wb_addr_match #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_OFF(LINE_OFF), .PTR_W(PTR_W)
  ) u_ld_match (
    .entries (entries_r),
    .head    (head_r),
    .cmp_addr(ld_addr),
    .hit     (ld_hit),
    .data    (ld_data),
    .line_hit(ld_line_s)
  );

  wb_addr_match #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_OFF(LINE_OFF), .PTR_W(PTR_W)
  ) u_miss_match (
    .entries (entries_r),
    .head    (head_r),
    .cmp_addr(miss_addr),
    .hit     (miss_hit_s),
    .data    (miss_data_s),
    .line_hit(line_conflict)
  );

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: a queue model of buffered stores
// is the scoreboard; drained writes are popped and compared as they appear.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [15:0] st_addr = 16'h0000;
  logic [15:0] st_data = 16'h0000;
  logic        st_ready;
  logic [15:0] ld_addr = 16'h0000;
  logic        ld_hit;
  logic [15:0] ld_data;
  logic [15:0] miss_addr = 16'h0000;
  logic        line_conflict;
  logic        mem_gnt = 1'b0;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        empty;
  logic        full;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } m_t;
  m_t model_q[$];

  store_write_buffer dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .miss_addr(miss_addr), .line_conflict(line_conflict),
    .mem_gnt(mem_gnt), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: check handshake/drain against the model, advance the edge, update the model.
  task automatic tick();
    logic exp_full, acc, drn, coal;
    m_t e;
    #1;
    if (!rst) begin
      exp_full = (model_q.size() == DEPTH);
      acc = st_valid && !exp_full;
      drn = mem_gnt && (model_q.size() > 0);
      n_tests++;
      if (st_ready !== !exp_full) begin
        n_fail++; $display("FAIL st_ready: got %b want %b", st_ready, !exp_full);
      end
      n_tests++;
      if (mem_wr_en !== drn) begin
        n_fail++; $display("FAIL mem_wr_en: got %b want %b", mem_wr_en, drn);
      end
      n_tests++;
      if (count !== 3'(model_q.size())) begin
        n_fail++; $display("FAIL count: got %0d want %0d", count, model_q.size());
      end
      if (drn) begin
        n_tests++;
        if (mem_addr !== model_q[0].addr || mem_wdata !== model_q[0].data) begin
          n_fail++;
          $display("FAIL drain_data: got %h/%h want %h/%h", mem_addr, mem_wdata,
                   model_q[0].addr, model_q[0].data);
        end
      end
    end else begin
      acc = 1'b0;
      drn = 1'b0;
      n_tests++;
      if (mem_wr_en !== 1'b0) begin
        n_fail++; $display("FAIL reset_cycle_write: got %b want 0", mem_wr_en);
      end
    end
    coal = acc && (model_q.size() > 0) && (model_q[model_q.size()-1].addr[15:1] == st_addr[15:1])
           && !(drn && model_q.size() == 1);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (coal) begin
        e = model_q[model_q.size()-1];
        e.data = st_data;
        model_q[model_q.size()-1] = e;
      end
      if (drn) void'(model_q.pop_front());
      if (acc && !coal) begin
        e.addr = {st_addr[15:1], 1'b0};
        e.data = st_data;
        model_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain_all();
    int budget = 0;
    st_valid = 1'b0;
    mem_gnt = 1'b1;
    while (model_q.size() > 0 && budget < 16) begin
      tick();
      budget++;
    end
    mem_gnt = 1'b0;
    #1;
    n_tests++;
    if (model_q.size() != 0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL drain_all: left %0d empty=%b want 0/1", model_q.size(), empty);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if ({empty, full, st_ready, mem_wr_en, ld_hit, line_conflict} !== 6'b101000) begin
      n_fail++;
      $display("FAIL reset_flags: got e%b f%b r%b w%b h%b c%b want e1 f0 r1 w0 h0 c0",
               empty, full, st_ready, mem_wr_en, ld_hit, line_conflict);
    end
    n_tests++;
    if (ld_data !== 16'h0000 || mem_addr !== 16'h0000 || mem_wdata !== 16'h0000 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %0d want 0 0 0 0", ld_data, mem_addr, mem_wdata, count);
    end
  endtask

  task automatic test_fill_and_drain();
    logic [15:0] exp_a;
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) store(16'h0010 + 16'(2 * i), 16'h00A1 + 16'(i));
    n_tests++;
    if (count !== 3'd4 || full !== 1'b1 || st_ready !== 1'b0) begin
      n_fail++; $display("FAIL full: got c%0d f%b r%b want c4 f1 r0", count, full, st_ready);
    end
    store(16'h0018, 16'h00A5);
    n_tests++;
    if (count !== 3'd4) begin
      n_fail++; $display("FAIL refused_store: count %0d want 4", count);
    end
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_a = 16'h0010 + 16'(2 * i);
      #1;
      n_tests++;
      if (mem_wr_en !== 1'b1 || mem_addr !== exp_a) begin
        n_fail++; $display("FAIL drain_order: got w%b %h want w1 %h", mem_wr_en, mem_addr, exp_a);
      end
      tick();
    end
    n_tests++;
    if (empty !== 1'b1 || mem_wr_en !== 1'b0) begin
      n_fail++; $display("FAIL drained: got e%b w%b want e1 w0", empty, mem_wr_en);
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_coalesce();
    store(16'h0020, 16'h1111);
    store(16'h0021, 16'h2222);
    ld_addr = 16'h0020;
    #1;
    n_tests++;
    if (count !== 3'd1 || ld_hit !== 1'b1 || ld_data !== 16'h2222) begin
      n_fail++; $display("FAIL coalesce: got c%0d h%b %h want c1 h1 2222", count, ld_hit, ld_data);
    end
    drain_all();
  endtask

  task automatic test_youngest_forward();
    store(16'h0030, 16'h0005);
    store(16'h0040, 16'h0006);
    store(16'h0030, 16'h0007);
    ld_addr = 16'h0030;
    #1;
    n_tests++;
    if (count !== 3'd3 || ld_hit !== 1'b1 || ld_data !== 16'h0007) begin
      n_fail++; $display("FAIL youngest: got c%0d h%b %h want c3 h1 0007", count, ld_hit, ld_data);
    end
    ld_addr = 16'h0041;
    #1;
    n_tests++;
    if (ld_hit !== 1'b1 || ld_data !== 16'h0006) begin
      n_fail++; $display("FAIL fwd_0040: got h%b %h want h1 0006", ld_hit, ld_data);
    end
    ld_addr = 16'h0050;
    #1;
    n_tests++;
    if (ld_hit !== 1'b0 || ld_data !== 16'h0000) begin
      n_fail++; $display("FAIL no_hit: got h%b %h want h0 0000", ld_hit, ld_data);
    end
    drain_all();
  endtask

  task automatic test_line_conflict();
    store(16'h0046, 16'h0BAD);
    miss_addr = 16'h0040;
    #1;
    n_tests++;
    if (line_conflict !== 1'b1) begin
      n_fail++; $display("FAIL line_hit: got %b want 1", line_conflict);
    end
    miss_addr = 16'h0050;
    #1;
    n_tests++;
    if (line_conflict !== 1'b0) begin
      n_fail++; $display("FAIL line_other: got %b want 0", line_conflict);
    end
    drain_all();
    miss_addr = 16'h0040;
    #1;
    n_tests++;
    if (line_conflict !== 1'b0) begin
      n_fail++; $display("FAIL line_after_drain: got %b want 0", line_conflict);
    end
  endtask

  task automatic test_back_to_back();
    mem_gnt = 1'b0;
    store(16'h0100, 16'h0001);
    store(16'h0102, 16'h0002);
    mem_gnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      store(16'h0104 + 16'(2 * k), 16'h0010 + 16'(k));
      n_tests++;
      if (count !== 3'd2) begin
        n_fail++; $display("FAIL push_pop_count: got %0d want 2", count);
      end
    end
    drain_all();
  endtask

  task automatic test_drain_head_no_merge();
    mem_gnt = 1'b0;
    store(16'h0200, 16'hAAAA);
    mem_gnt = 1'b1;
    store(16'h0200, 16'hBBBB);
    #1;
    n_tests++;
    if (count !== 3'd1 || mem_wdata !== 16'hBBBB) begin
      n_fail++; $display("FAIL head_no_merge: got c%0d %h want c1 bbbb", count, mem_wdata);
    end
    drain_all();
    mem_gnt = 1'b1;
    store(16'h0300, 16'h0303);
    #1;
    n_tests++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 16'h0300) begin
      n_fail++; $display("FAIL push_empty_next: got w%b %h want w1 0300", mem_wr_en, mem_addr);
    end
    drain_all();
  endtask

  task automatic test_reset_mid_drain();
    mem_gnt = 1'b0;
    store(16'h0400, 16'h0041);
    store(16'h0402, 16'h0042);
    store(16'h0404, 16'h0043);
    mem_gnt = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (empty !== 1'b1 || mem_wr_en !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL reset_mid: got e%b w%b c%0d want e1 w0 c0", empty, mem_wr_en, count);
    end
    tick();
    mem_gnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_and_drain();
    test_coalesce();
    test_youngest_forward();
    test_line_conflict();
    test_back_to_back();
    test_drain_head_no_merge();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Write-through store buffer between the MEM-stage data cache/memory wrapper and the shared 4-cycle main memory port.
- Absorbs stores from the pipeline so they do not stall MEM while the fill FSM owns memory.
- Drains one store per granted cycle.
- Provides load forwarding and a line-conflict flag so a D/I miss fill never reads stale memory.

Parameters:
- DEPTH, 4, number of buffered stores (power of 2, ≥2)
- ADDR_W, 16, byte address width
- DATA_W, 16, store data width (one word)
- LINE_OFF, 4, byte-offset bits of a cache line (8 words × 2 bytes)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  MEM stage presents a store
- st_addr  in  ADDR_W  store byte address (bit0 ignored)
- st_data  in  DATA_W  store data
- st_ready  out  1  store accepted this cycle when st_valid&st_ready
- ld_addr  in  ADDR_W  MEM-stage load address for forwarding check
- ld_hit  out  1  a buffered store matches ld_addr[ADDR_W-1:1]
- ld_data  out  DATA_W  data of the youngest matching entry
- miss_addr  in  ADDR_W  address the fill FSM is about to fetch
- line_conflict  out  1  a buffered entry lies in miss_addr's line
- mem_gnt  in  1  arbiter grants memory port to buffer this cycle
- mem_wr_en  out  1  write to memory this cycle
- mem_addr  out  ADDR_W  write address (head entry)
- mem_wdata  out  DATA_W  write data (head entry)
- empty  out  1  no entries
- full  out  1  DEPTH entries held
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Circular FIFO: head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH; separate count register.
- Reset: on clk edge with rst=1, pointers=0, count=0, all entry valid bits=0.
  - Resulting outputs: empty=1, full=0, st_ready=1, mem_wr_en=0, ld_hit=0, line_conflict=0, ld_data=0, mem_addr=0, mem_wdata=0.
  - rst mid-drain discards all pending stores; no memory write in the reset cycle.
- st_ready = ~full. No same-cycle bypass when full: a store is refused even if a drain occurs that cycle.
- Drain (combinational):
  - mem_wr_en = ~empty & mem_gnt.
  - mem_addr/mem_wdata = head entry; both are 0 when empty.
  - Head advances at the edge when mem_wr_en=1.
- Enqueue: on st_valid&st_ready, the entry is written at tail and tail advances. The entry is visible to forwarding the next cycle.
- Coalescing: if st_addr[ADDR_W-1:1] equals the youngest valid entry's address, data is overwritten in place; no new entry, count unchanged.
  - Exception: if that youngest entry is also the head being drained this cycle, a new entry is allocated instead.
- Simultaneous push+pop: count unchanged; pointers both advance.
- Push into empty buffer with mem_gnt=1: not drained the same cycle; first drain is the next cycle at earliest.
- ld_hit: compare ld_addr[ADDR_W-1:1] against all valid entries, including the head draining this cycle.
  - ld_data selects the youngest match (nearest tail); 0 when no hit. Purely combinational, zero latency.
- line_conflict: any valid entry with addr[ADDR_W-1:LINE_OFF] == miss_addr[ADDR_W-1:LINE_OFF].
  - The miss arbiter must hold the fill and grant the buffer while line_conflict=1.
- count: incremented/decremented exactly once per push/pop; full = (count==DEPTH); empty = (count==0).

Decomposition:
- Shared package: ADDR_W, DATA_W, LINE_OFF, DEPTH defaults, WORD_LSB=1 constant, wb entry struct/typedef {valid, addr, data}.
- One sub-module: wb_addr_match.
  - Parameterised CAM compare over DEPTH entries with head pointer input.
  - Returns hit, youngest-match data, and line-match OR.
  - Instantiated twice: once for loads, once for the miss line.

Test Plan:
- Reset then 4 stores 0x0010/0x0012/0x0014/0x0016 data 0xA1..0xA4, mem_gnt=0 -> count=4, full=1, st_ready=0; 5th store refused and count stays 4.
- Hold mem_gnt=1 from full -> mem_wr_en=1 for 4 consecutive cycles, addresses 0x0010→0x0016 in order; then empty=1, mem_wr_en=0.
- Store 0x0020=0x1111 then 0x0021=0x2222 (same word, mem_gnt=0) -> count=1; ld_addr=0x0020 gives ld_hit=1, ld_data=0x2222.
- Stores 0x0030=0x5, 0x0040=0x6, 0x0030=0x7 (non-youngest match) -> count=3; ld_addr=0x0030 gives ld_data=0x7 (youngest).
- Entry at 0x0046, miss_addr=0x0040 -> line_conflict=1; after drain, line_conflict=0. miss_addr=0x0050 -> 0 throughout.
- Push and pop in the same cycle at count=2 -> count stays 2; pointers wrap past DEPTH-1 correctly. Assert rst with 3 entries -> next cycle empty=1 and no mem_wr_en.
